// File: rtl/fetch_unit.sv
// Instruction fetch stage: assembles big-endian 16-bit instructions from a byte-wide
// req/ack memory into a small prefetch FIFO and hands them on over valid/ready.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [15:0] ResetPcC = {RESET_PC[15:1], 1'b0};

  typedef enum logic [1:0] {StIdle, StFetchHi, StFetchLo} state_e;

  state_e          state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic [7:0]      hi_q, hi_d;
  logic [15:0]     instr_mem_q [DEPTH];
  logic [15:0]     pc_mem_q    [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  assign instr_valid = (count_q != '0);
  assign instr       = instr_mem_q[rd_ptr_q];
  assign instr_pc    = pc_mem_q[rd_ptr_q];
  assign mem_req     = (state_q != StIdle);
  // fetch_pc is always even, so +1 only sets bit 0.
  assign mem_addr    = (state_q == StFetchLo) ? {pc_q[15:1], 1'b1} : pc_q;

  assign pop     = instr_valid && instr_ready;
  assign push    = (state_q == StFetchLo) && mem_ack && !redirect;
  assign count_d = count_q + CntW'(push) - CntW'(pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hi_d    = hi_q;
    unique case (state_q)
      StIdle: begin
        if (count_q < DepthC) state_d = StFetchHi;
      end
      StFetchHi: begin
        if (mem_ack) begin
          hi_d    = mem_rdata;
          state_d = StFetchLo;
        end
      end
      StFetchLo: begin
        if (mem_ack) begin
          pc_d    = pc_q + 16'd2;
          state_d = (count_d < DepthC) ? StFetchHi : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Redirect drops any in-flight byte, including an ack arriving this cycle.
    if (redirect) begin
      state_d = StIdle;
      pc_d    = {redirect_pc[15:1], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= ResetPcC;
      hi_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hi_q    <= hi_d;
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          instr_mem_q[wr_ptr_q] <= {hi_q, mem_rdata};
          pc_mem_q[wr_ptr_q]    <= pc_q;
          wr_ptr_q              <= wr_ptr_q + PtrW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
        count_q <= count_d;
      end
    end
  end

`ifndef SYNTHESIS
  push_never_full_a: assert property (@(posedge clock) disable iff (reset)
    push |-> (count_q < DepthC));
`endif

endmodule
